// File: rtl/piso_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : piso_pkg                                                         |
// | Brief    : Shared FSM state type and counter sizing for piso_serializer.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter must reach WIDTH, which is the parity slot when parity is built in.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W_DEFAULT = piso_cnt_w(4);

endpackage : piso_pkg

`default_nettype wire

// File: rtl/piso_serializer.sv
// +-----------------------------------------------------------------------------+
// | Module   : piso_serializer                                                  |
// | Brief    : Parallel-in serial-out transmitter with one-word hold register.  |
// |            Optional even-parity bit per frame when PISO_PARITY_EN is set.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    output logic             load_ready,
    input  logic [WIDTH-1:0] PI,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CNT_W = piso_cnt_w(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;

    logic               w_accept;
    logic               w_is_last;
    logic               w_data_bit;
    logic [WIDTH-1:0]   w_shifted;

    assign w_accept  = load & ~hold_full_q;
    assign w_is_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign w_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;

    // Parity is captured at frame start so the shift register can drain freely.
    assign w_data_bit = (cnt_q == CNT_W'(WIDTH)) ? parity_q
                      : (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
`else
    assign w_data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    shreg_d = PI;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^PI;
`endif
                end
            end
            SHIFT: begin
                if (w_is_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
`ifdef PISO_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end else if (w_accept) begin
                        shreg_d = PI;
`ifdef PISO_PARITY_EN
                        parity_d = ^PI;
`endif
                    end else begin
                        shreg_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = w_shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (w_accept) begin
                        hold_d      = PI;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // All outputs decode flops only, so reset clears them without a clock edge.
    assign so_valid   = (state_q == SHIFT);
    assign so         = so_valid & w_data_bit;
    assign so_last    = w_is_last;
    assign busy       = so_valid | hold_full_q;
    assign load_ready = ~hold_full_q;

endmodule : piso_serializer

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_piso_serializer                                               |
// | Brief    : Directed bench for piso_serializer (MSB-first and LSB-first).    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int F = 5;
`else
    localparam int F = 4;
`endif

    logic       clk;
    logic       rst;
    logic       load,   load_l;
    logic       load_ready, load_ready_l;
    logic [3:0] PI,     PI_l;
    logic       so,     so_l;
    logic       so_valid, so_valid_l;
    logic       so_last,  so_last_l;
    logic       busy,     busy_l;

    int n_vec;
    int n_bad;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_ready (load_ready),
        .PI         (PI),
        .so         (so),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .busy       (busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .load       (load_l),
        .load_ready (load_ready_l),
        .PI         (PI_l),
        .so         (so_l),
        .so_valid   (so_valid_l),
        .so_last    (so_last_l),
        .busy       (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] word, input bit lsb);
        if (lsb) begin load_l = 1'b1; PI_l = word; end
        else     begin load   = 1'b1; PI   = word; end
        tick();
        load   = 1'b0;
        load_l = 1'b0;
    endtask

    // exp holds frame bits in send order, MSB of exp first; bit 0 is the parity slot.
    task automatic run_frame(input string tag, input logic [4:0] exp, input bit lsb,
                             input bit chain, input logic [3:0] nxt);
        for (int i = 0; i < F; i++) begin
            if (!lsb) begin
                chk($sformatf("%s.so[%0d]", tag, i),    so,       exp[4-i]);
                chk($sformatf("%s.valid[%0d]", tag, i), so_valid, 1);
                chk($sformatf("%s.last[%0d]", tag, i),  so_last,  (i == F-1));
                chk($sformatf("%s.busy[%0d]", tag, i),  busy,     1);
            end else begin
                chk($sformatf("%s.so[%0d]", tag, i),    so_l,       exp[4-i]);
                chk($sformatf("%s.valid[%0d]", tag, i), so_valid_l, 1);
                chk($sformatf("%s.last[%0d]", tag, i),  so_last_l,  (i == F-1));
                chk($sformatf("%s.busy[%0d]", tag, i),  busy_l,     1);
            end
            if (chain && i == F-1) begin
                if (lsb) begin load_l = 1'b1; PI_l = nxt; end
                else     begin load   = 1'b1; PI   = nxt; end
            end
            tick();
            load   = 1'b0;
            load_l = 1'b0;
        end
        if (!chain) begin
            chk({tag, ".idle_valid"}, lsb ? so_valid_l : so_valid, 0);
            chk({tag, ".idle_so"},    lsb ? so_l       : so,       0);
            chk({tag, ".idle_busy"},  lsb ? busy_l     : busy,     0);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        load   = 1'b0;
        load_l = 1'b0;
        PI     = 4'b0000;
        PI_l   = 4'b0000;

        repeat (2) tick();
        chk("rst.so",         so,         0);
        chk("rst.valid",      so_valid,   0);
        chk("rst.last",       so_last,    0);
        chk("rst.busy",       busy,       0);
        chk("rst.load_ready", load_ready, 1);
        rst = 1'b1;
        tick();

        // Single word from IDLE; 1011 has odd weight so parity slot is 1.
        start(4'b1011, 1'b0);
        run_frame("t1", 5'b10111, 1'b0, 1'b0, 4'b0000);

        // Three back-to-back words; 0110 is junk that must never be accepted.
        load = 1'b1;
        PI   = 4'b1001;
        tick();
        for (int c = 1; c <= 3*F; c++) begin
            int         fi;
            int         k;
            logic [4:0] fv;
            logic       er;
            fi = (c - 1) / F;
            k  = (c - 1) % F;
            fv = (fi == 0) ? 5'b10010 : (fi == 1) ? 5'b00110 : 5'b11110;
            er = (c == 1) || (c == F + 1) || (c > 2*F);
            chk($sformatf("t2.so[%0d]", c),    so,         fv[4-k]);
            chk($sformatf("t2.valid[%0d]", c), so_valid,   1);
            chk($sformatf("t2.last[%0d]", c),  so_last,    (k == F-1));
            chk($sformatf("t2.busy[%0d]", c),  busy,       1);
            chk($sformatf("t2.rdy[%0d]", c),   load_ready, er);
            if (c == 1)              begin load = 1'b1; PI = 4'b0011; end
            else if (c <= F)         begin load = 1'b1; PI = 4'b0110; end
            else if (c == F + 1)     begin load = 1'b1; PI = 4'b1111; end
            else                     begin load = 1'b0; PI = 4'b0110; end
            tick();
        end
        chk("t2.end_valid", so_valid,   0);
        chk("t2.end_busy",  busy,       0);
        chk("t2.end_rdy",   load_ready, 1);

        // LSB-first, with a second word accepted directly on the last-bit edge.
        start(4'b1010, 1'b1);
        run_frame("t4a", 5'b01010, 1'b1, 1'b1, 4'b0101);
        run_frame("t4b", 5'b10100, 1'b1, 1'b0, 4'b0000);

        // Asynchronous reset mid-frame with a word held.
        start(4'b1011, 1'b0);
        load = 1'b1;
        PI   = 4'b1111;
        tick();
        load = 1'b0;
        chk("t5.pre_rdy",   load_ready, 0);
        chk("t5.pre_valid", so_valid,   1);
        #2 rst = 1'b0;
        #1;
        chk("t5.valid", so_valid,   0);
        chk("t5.busy",  busy,       0);
        chk("t5.so",    so,         0);
        chk("t5.last",  so_last,    0);
        chk("t5.rdy",   load_ready, 1);
        #1 rst = 1'b1;
        tick();
        chk("t5.post_valid", so_valid, 0);
        start(4'b0011, 1'b0);
        run_frame("t5f", 5'b00110, 1'b0, 1'b0, 4'b0000);
        tick();
        chk("t5.no_stale", so_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_piso_serializer

`default_nettype wire
